// File: rtl/dram_port_arbiter.sv
// Two-requester arbiter in front of the DRAM wrapper's single request port.
// Round-robin with an urgent override for m0, one transaction in flight, completion timeout, soft abort.
module dram_port_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_reset,
  input  logic                  m0_req,
  input  logic                  m0_urgent,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [7:0]            timeout_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int            CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          grant;      // 0 = m0, 1 = m1 for the transaction in flight
  logic          last_grant;
  logic [CW-1:0] wait_cnt;
  logic          pick_m1;
  logic          any_req;

  // Urgent m0 first, then a lone requester, then whoever was not served last.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_req && m0_urgent) begin
      pick_m1 = 1'b0;
    end else if (m0_req && m1_req) begin
      pick_m1 = ~last_grant;
    end else begin
      pick_m1 = m1_req;
    end
  end

  assign any_req   = m0_req | m1_req;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= '0;
      timeout_cnt <= '0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      if (soft_reset) begin
        state       <= IDLE;
        mem_req     <= 1'b0;
        last_grant  <= 1'b1;
        timeout_cnt <= '0;
        wait_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (any_req) begin
              grant      <= pick_m1;
              last_grant <= pick_m1;
              mem_we     <= pick_m1 ? m1_we    : m0_we;
              mem_addr   <= pick_m1 ? m1_addr  : m0_addr;
              mem_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
              mem_req    <= 1'b1;
              wait_cnt   <= '0;
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            // A completion on the last wait cycle still counts as a success.
            if (mem_ack) begin
              mem_req <= 1'b0;
              if (grant) begin
                m1_rdata <= mem_rdata;
                m1_ack   <= 1'b1;
              end else begin
                m0_rdata <= mem_rdata;
                m0_ack   <= 1'b1;
              end
              state <= DONE;
            end else if (wait_cnt == WAIT_LAST) begin
              mem_req <= 1'b0;
              if (timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 8'd1;
              end
              if (grant) begin
                m1_ack <= 1'b1;
                m1_err <= 1'b1;
              end else begin
                m0_ack <= 1'b1;
                m0_err <= 1'b1;
              end
              state <= DONE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: wrapper responder with programmable ack delay,
// expected-completion queue checked on every mX_ack.
module tb_dram_port_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int W  = 3 + AW + 2 * DW;  // {port, err, we, addr, wdata, rdata}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soft_reset = 1'b0;
  logic          m0_req = 1'b0, m0_urgent = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack, m0_err;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack, m1_err;
  logic [DW-1:0] m1_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [7:0]    timeout_cnt;
  logic [1:0]    state_dbg;

  dram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .soft_reset(soft_reset),
    .m0_req(m0_req), .m0_urgent(m0_urgent), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_cnt(timeout_cnt), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // wrapper responder: ack in ISSUE cycle ack_delay (-1 = never)
  int            ack_delay = 0;
  logic [DW-1:0] resp_data = '0;
  int            issue_cyc = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (issue_cyc == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = resp_data;
        end
        issue_cyc++;
      end else begin
        issue_cyc = 0;
      end
    end
  end

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] exp_rdata[2];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ack_cnt = 0;
  int            req_hi_cnt = 0;
  int            mem_ack_cyc = 0;
  int            last_ack_cyc = 0;
  int            ack_cyc_q[$];
  logic          ack0_now = 1'b0, ack1_now = 1'b0, mack_now = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic err, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    exp_q.push_back({p, err, we, addr, wdata, rdata});
  endtask

  // one cycle; outputs sampled on the falling edge, completions scored here
  task automatic tick();
    logic [W-1:0] obs;
    logic [W-1:0] exp_e;
    @(negedge clk);
    ack0_now = m0_ack;
    ack1_now = m1_ack;
    mack_now = mem_ack;
    if (mem_req) req_hi_cnt++;
    if (mem_ack) mem_ack_cyc = cyc;
    if (m0_ack || m1_ack) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      ack_cyc_q.push_back(cyc);
      check("ack_onehot", m0_ack & m1_ack, 0);
      obs = {m1_ack, (m1_ack ? m1_err : m0_err), mem_we, mem_addr, mem_wdata,
             (m1_ack ? m1_rdata : m0_rdata)};
      if (exp_q.size() == 0) begin
        check("ack_unexpected", obs, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("ack", obs, exp_e);
      end
    end
  endtask

  task automatic drive(input logic p, input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (p) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // single transaction on one port; requester drops req once it sees its ack
  task automatic do_txn(input logic p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int delay, input logic to_exp);
    logic [DW-1:0] rd;
    logic          done;
    ack_delay = delay;
    rd = to_exp ? exp_rdata[p] : resp_data;
    exp_rdata[p] = rd;
    push_exp(p, to_exp, we, addr, wdata, rd);
    drive(p, 1'b1, we, addr, wdata);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      done = p ? ack1_now : ack0_now;
    end
    check("txn_wait", done, 1);
    drive(p, 1'b0, we, addr, wdata);
  endtask

  // wait for n completions; optionally drop each requester on its ack
  task automatic wait_acks(input int n, input logic drop_each);
    int base;
    base = ack_cnt;
    for (int i = 0; i < 300 && (ack_cnt - base) < n; i++) begin
      tick();
      if (drop_each && ack0_now) begin m0_req = 1'b0; m0_urgent = 1'b0; end
      if (drop_each && ack1_now) m1_req = 1'b0;
    end
    check("wait_acks", ack_cnt - base, n);
  endtask

  initial begin
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    // reset state
    #12;
    check("rst_ctl", {m0_ack, m1_ack, m0_err, m1_err, mem_req, mem_we, busy}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    check("rst_tocnt", timeout_cnt, 0);
    check("rst_state", state_dbg, 0);
    tick();
    rst_n = 1'b1;

    // contention from reset: m0 first, then strict alternation, 3 cycles apart
    ack_delay = 0;
    resp_data = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_exp(1'b0, 1'b0, 1'b1, 27'h10, 32'hA5A5_A5A5, resp_data);
      else            push_exp(1'b1, 1'b0, 1'b0, 27'h20, 32'h0, resp_data);
    end
    exp_rdata[0] = resp_data;
    exp_rdata[1] = resp_data;
    ack_cyc_q.delete();
    drive(1'b0, 1'b1, 1'b1, 27'h10, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, 1'b0, 27'h20, 32'h0);
    wait_acks(6, 1'b0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    for (int i = 1; i < ack_cyc_q.size(); i++) check("rr_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 3);
    tick();

    // single read, ack after 5 ISSUE cycles
    resp_data = 32'hDEAD_BEEF;
    do_txn(1'b1, 1'b0, 27'h0000123, 32'h0, 5, 1'b0);
    check("rd_ack_lat", last_ack_cyc - mem_ack_cyc, 1);
    check("rd_rdata", m1_rdata, 32'hDEAD_BEEF);
    tick();

    // urgent override: after an m0 grant, urgent m0 still beats m1
    resp_data = 32'h0BAD_F00D;
    do_txn(1'b0, 1'b0, 27'h44, 32'h0, 0, 1'b0);
    resp_data = 32'h7777_1111;
    push_exp(1'b0, 1'b0, 1'b1, 27'h55, 32'hCAFE_0001, resp_data);
    push_exp(1'b1, 1'b0, 1'b1, 27'h66, 32'hCAFE_0002, resp_data);
    exp_rdata[0] = resp_data;
    exp_rdata[1] = resp_data;
    m0_urgent = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 27'h55, 32'hCAFE_0001);
    drive(1'b1, 1'b1, 1'b1, 27'h66, 32'hCAFE_0002);
    wait_acks(2, 1'b1);
    tick();

    // random single transactions
    for (int i = 0; i < 8; i++) begin
      logic p;
      p = 1'($urandom_range(0, 1));
      resp_data = $urandom;
      do_txn(p, 1'($urandom_range(0, 1)), 27'($urandom), $urandom, int'($urandom_range(0, 6)), 1'b0);
    end

    // timeout: mem_req high for TO cycles, err set, rdata untouched
    req_hi_cnt = 0;
    do_txn(1'b0, 1'b1, 27'h99, 32'h1, -1, 1'b1);
    check("to_req_cycles", req_hi_cnt, TO);
    check("to_cnt_one", timeout_cnt, 1);
    check("to_rdata_kept", m0_rdata, exp_rdata[0]);
    for (int i = 0; i < 299; i++) do_txn(1'b0, 1'b0, 27'($urandom), $urandom, -1, 1'b1);
    check("to_cnt_sat", timeout_cnt, 255);

    // soft abort together with mem_ack in ISSUE cycle 3
    ack_delay = 3;
    resp_data = 32'h5555_AAAA;
    drive(1'b1, 1'b1, 1'b0, 27'h321, 32'h0);
    mack_now = 1'b0;
    for (int i = 0; i < 20 && !mack_now; i++) tick();
    check("abort_mem_ack", mack_now, 1);
    check("abort_in_issue", state_dbg, 1);
    soft_reset = 1'b1;
    m1_req = 1'b0;
    @(posedge clk);
    #1;
    soft_reset = 1'b0;
    tick();
    check("abort_state", state_dbg, 0);
    check("abort_ctl", {mem_req, busy, m0_ack, m1_ack}, 0);
    check("abort_tocnt", timeout_cnt, 0);
    check("abort_rdata", m1_rdata, exp_rdata[1]);
    repeat (4) tick();

    // async reset in ISSUE: outputs drop without a clock edge
    ack_delay = -1;
    drive(1'b0, 1'b1, 1'b0, 27'h700, 32'h0);
    tick();
    tick();
    check("arst_pre", {mem_req, busy}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_async", {mem_req, busy}, 0);
    m0_req = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    check("arst_tocnt", timeout_cnt, 0);
    ack_delay = 0;
    resp_data = 32'h0F0F_0F0F;
    push_exp(1'b0, 1'b0, 1'b0, 27'h11, 32'h0, resp_data);
    push_exp(1'b1, 1'b0, 1'b1, 27'h22, 32'h3, resp_data);
    drive(1'b0, 1'b1, 1'b0, 27'h11, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 27'h22, 32'h3);
    wait_acks(2, 1'b1);
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single request port of the DRAM wrapper between two requesters: m0 is the I2S sample writer (real-time), m1 is the SPI host bridge (read/write).
- Round-robin arbitration with an urgent override for m0, one outstanding transaction at a time, a completion timeout and a synchronous soft abort.
- Sits between the capture/SPI logic and the DRAM wrapper in the top level.

Parameters:
- ADDR_WIDTH, 27, word address width.
- DATA_WIDTH, 32, data bus width.
- TIMEOUT, 1024, cycles of mem_req without mem_ack before abort; must be ≥2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- soft_reset  input  1  synchronous abort/clear, active-high.
- m0_req, m1_req  input  1  request; held with fields stable until the matching ack.
- m0_urgent  input  1  m0 wins any arbitration while set.
- m0_we, m1_we  input  1  1 = write, 0 = read.
- m0_addr, m1_addr  input  ADDR_WIDTH  word address.
- m0_wdata, m1_wdata  input  DATA_WIDTH  write data.
- m0_ack, m1_ack  output  1  one-cycle completion pulse.
- m0_err, m1_err  output  1  valid with ack; 1 = timed out.
- m0_rdata, m1_rdata  output  DATA_WIDTH  read data, valid with ack.
- mem_req  output  1  request to the wrapper, level, held until mem_ack.
- mem_we  output  1  registered copy of the granted we.
- mem_addr  output  ADDR_WIDTH  registered copy of the granted address.
- mem_wdata  output  DATA_WIDTH  registered copy of the granted write data.
- mem_ack  input  1  one-cycle completion from the wrapper.
- mem_rdata  input  DATA_WIDTH  valid with mem_ack on reads.
- busy  output  1  state is not IDLE.
- timeout_cnt  output  8  saturating count of timeouts.

Behaviour:

Reset:
- rst_n low asynchronously forces state IDLE, last_grant = 1, and every output to 0, including mem_req.

States and transitions:
- IDLE
  - Samples the requests. If none is active, stays in IDLE.
  - Winner selection, in order:
    - m0_req & m0_urgent → m0.
    - Only one request active → that requester.
    - Both active → the requester not equal to last_grant.
  - On the clock edge: latch the winner's we/addr/wdata into mem_*, set grant and last_grant, go to ISSUE.
- ISSUE
  - mem_req = 1; the wait counter increments from 0.
  - On mem_ack: capture mem_rdata into the granted mX_rdata, go to DONE with err = 0.
  - When the counter reaches TIMEOUT-1 without mem_ack: drop mem_req, increment timeout_cnt (saturating at 255), go to DONE with err = 1. mX_rdata is left unchanged on timeout.
- DONE
  - The granted mX_ack is high for exactly this one cycle; mX_err is valid in the same cycle.
  - Unconditionally return to IDLE.

Timing and latency:
- mem_req is first high on the cycle after the request is sampled in IDLE.
- If mem_ack arrives at cycle k of ISSUE, mX_ack is high at k+1.
- Minimum cycle time from request to ack: 3 cycles (IDLE, ISSUE with an immediate mem_ack, DONE).

Request hold and re-arbitration:
- A requester must keep req and its fields stable until it sees ack.
- If req is still high in the IDLE cycle after DONE, that is a new transaction.
- Back-to-back requests from both requesters strictly alternate unless m0_urgent is set.
- Requests arriving during ISSUE or DONE wait; they are never dropped.
- A requester that withdraws req before its grant is simply not served.

Other rules:
- mem_req is never high in IDLE or DONE. A mem_ack seen outside ISSUE is ignored.
- soft_reset high in any state, on that edge: go to IDLE, mem_req = 0, no ack issued, last_grant = 1, timeout_cnt = 0.
  - The aborted requester must re-issue.
  - soft_reset has precedence over a simultaneous mem_ack.
- A simultaneous mem_ack and timeout edge counts as a completion (ack wins, err = 0).
- Address and data pass through unmodified; no width conversion.

Test Plan:
- Single read: m1 read at addr 0x0000123, mem_ack after 5 ISSUE cycles with rdata 0xDEADBEEF → m1_ack pulses one cycle after mem_ack, m1_rdata = 0xDEADBEEF, m1_err = 0, m0_ack stays 0.
- Contention: both request continuously from reset (m0 write 0xA5A5A5A5 @0x10, m1 read @0x20), wrapper acks in 1 cycle → grants are m0, m1, m0, m1…; each ack exactly 3 cycles apart.
- Urgent override: m0_urgent = 1, last_grant = 0, both requesting → m0 granted again; mem_addr = m0_addr.
- Timeout: TIMEOUT = 16, never assert mem_ack → mem_req high for 16 cycles then low, m0_ack = 1 with m0_err = 1, timeout_cnt = 1; 300 timeouts → timeout_cnt saturates at 255.
- Soft abort: soft_reset during ISSUE (cycle 3) together with mem_ack → next cycle IDLE, mem_req = 0, no ack, busy = 0, timeout_cnt = 0.
- Async reset mid-transaction: rst_n low during ISSUE → mem_req and busy drop without waiting for a clock edge; after release, first contention goes to m0.
